dw_down_scheduler: RTL and testbench

DW_DOWN_SCHEDULER -- requirements
Module: dw_down_scheduler

---
 rtl/dw_down_scheduler.sv | 155 +++++++++++++++
 tb/tb_dw_down_scheduler.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/dw_down_scheduler.sv
// dw_down_scheduler
// Round-robin scheduler that grants one requester at a time to a shared
// wide-to-narrow down-converter. Each grant covers a whole burst of
// (len+1) wide words. The scheduler then waits for the converter to drain
// before it arbitrates again, so bursts never interleave inside the converter.
module dw_down_scheduler #(
    parameter int NUM_REQ  = 4,
    parameter int INPUT_DW = 512,
    parameter int LEN_W    = 8,
    localparam int ID_W    = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic                        clk_i,
    input  logic                        rst_ni,
    input  logic                        enable_i,
    input  logic [NUM_REQ-1:0]          req_valid_i,
    input  logic [NUM_REQ*INPUT_DW-1:0] req_data_i,
    input  logic [NUM_REQ*LEN_W-1:0]    req_len_i,
    output logic [NUM_REQ-1:0]          req_ready_o,
    output logic [INPUT_DW-1:0]         conv_data_o,
    output logic                        conv_valid_o,
    input  logic                        conv_ready_i,
    input  logic                        conv_idle_i,
    output logic [ID_W-1:0]             grant_id_o,
    output logic                        busy_o,
    output logic                        burst_done_o
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_XFER  = 2'd1,
        S_DRAIN = 2'd2
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;

    logic [ID_W-1:0]    r_grant;      // current / last granted requester
    logic [ID_W-1:0]    r_last_ptr;   // requester that completed the last burst
    logic [LEN_W-1:0]   r_len;        // burst length minus one, frozen at grant
    logic [LEN_W-1:0]   r_beat;       // wide words accepted so far in this burst

    logic               w_found;
    logic [ID_W-1:0]    w_winner;
    logic               w_grant;      // arbitration fires this cycle
    logic               w_hs;         // converter accepts a word this cycle
    logic               w_last_beat;  // the accepted word closes the burst
    logic               w_done;       // converter drained, burst retires

    // Round-robin pick: first valid requester strictly above r_last_ptr,
    // otherwise wrap and take the first valid one at or below it.
    always_comb begin
        w_found  = 1'b0;
        w_winner = r_last_ptr;
        for (int j = 0; j < NUM_REQ; j++) begin
            if (!w_found && (j > int'(r_last_ptr)) && req_valid_i[j]) begin
                w_found  = 1'b1;
                w_winner = ID_W'(j);
            end
        end
        for (int j = 0; j < NUM_REQ; j++) begin
            if (!w_found && (j <= int'(r_last_ptr)) && req_valid_i[j]) begin
                w_found  = 1'b1;
                w_winner = ID_W'(j);
            end
        end
    end

    // Next-state decode and all state-dependent outputs.
    always_comb begin
        w_state_nxt  = r_state;
        w_grant      = 1'b0;
        w_hs         = 1'b0;
        w_last_beat  = 1'b0;
        w_done       = 1'b0;
        conv_valid_o = 1'b0;
        req_ready_o  = '0;
        busy_o       = 1'b0;
        burst_done_o = 1'b0;
        case (r_state)
            S_IDLE: begin
                // enable_i only gates new grants; it never aborts a burst.
                if (enable_i && w_found) begin
                    w_grant     = 1'b1;
                    w_state_nxt = S_XFER;
                end
            end
            S_XFER: begin
                busy_o               = 1'b1;
                conv_valid_o         = req_valid_i[r_grant];
                req_ready_o[r_grant] = conv_ready_i;
                // A requester that drops valid mid-burst merely stalls.
                w_hs                 = req_valid_i[r_grant] & conv_ready_i;
                w_last_beat          = w_hs && (r_beat == r_len);
                if (w_last_beat)
                    w_state_nxt = S_DRAIN;
            end
            S_DRAIN: begin
                // Hold off the next grant until the converter has emitted
                // every narrow beat of the final wide word.
                busy_o = 1'b1;
                if (conv_idle_i) begin
                    w_done       = 1'b1;
                    burst_done_o = 1'b1;
                    w_state_nxt  = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Wide-word mux from the granted requester; the converter ignores it
    // whenever conv_valid_o is low, so it needs no state gating.
    always_comb begin
        conv_data_o = req_data_i[r_grant*INPUT_DW +: INPUT_DW];
    end

    assign grant_id_o = r_grant;

    // State register; reset drops any burst in flight without a done pulse.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni)
            r_state <= S_IDLE;
        else
            r_state <= w_state_nxt;
    end

    // Grant, length capture and round-robin pointer. r_last_ptr resets to
    // the top index so that requester 0 is searched first.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_grant    <= '0;
            r_last_ptr <= ID_W'(NUM_REQ - 1);
            r_len      <= '0;
        end else begin
            if (w_grant) begin
                r_grant <= w_winner;
                r_len   <= req_len_i[w_winner*LEN_W +: LEN_W];
            end
            if (w_done)
                r_last_ptr <= r_grant;
        end
    end

    // Beat counter, compared before increment: at r_len = all-ones the last
    // word is taken at r_beat = all-ones and the counter never wraps.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni)
            r_beat <= '0;
        else if (w_grant)
            r_beat <= '0;
        else if (w_hs && !w_last_beat)
            r_beat <= r_beat + 1'b1;
    end

endmodule

// File: tb/tb_dw_down_scheduler.sv
// Directed bench for dw_down_scheduler: 4 requesters, 16-bit words, LEN_W=2.
module tb_dw_down_scheduler;

    localparam int NR = 4;
    localparam int DW = 16;
    localparam int LW = 2;

    logic            clk;
    logic            rst_n;
    logic            en;
    logic [NR-1:0]   vld;
    logic [NR*DW-1:0] dat;
    logic [NR*LW-1:0] len;
    logic [NR-1:0]   rdy;
    logic [DW-1:0]   cdat;
    logic            cvld;
    logic            crdy;
    logic            cidle;
    logic [1:0]      gid;
    logic            busy;
    logic            done;

    dw_down_scheduler #(.NUM_REQ(NR), .INPUT_DW(DW), .LEN_W(LW)) dut (
        .clk_i        (clk),
        .rst_ni       (rst_n),
        .enable_i     (en),
        .req_valid_i  (vld),
        .req_data_i   (dat),
        .req_len_i    (len),
        .req_ready_o  (rdy),
        .conv_data_o  (cdat),
        .conv_valid_o (cvld),
        .conv_ready_i (crdy),
        .conv_idle_i  (cidle),
        .grant_id_o   (gid),
        .busy_o       (busy),
        .burst_done_o (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_pass = 0;
    int hs_cnt = 0;
    int gn     = 0;
    logic [1:0] glog [16];

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    // Inputs change 2ns after the falling edge; outputs are checked 1ns later.
    task automatic nxt();
        @(negedge clk);
        #2;
    endtask

    // Sample just ahead of each rising edge: count accepted words and log the
    // requester that owned every completed burst.
    always begin
        @(negedge clk);
        #4;
        if (cvld && crdy) hs_cnt++;
        if (done) begin
            if (gn < 16) glog[gn] = gid;
            gn++;
        end
    end

    task automatic do_reset();
        rst_n = 1'b0;
        vld   = '0;
        nxt();
        nxt();
        rst_n  = 1'b1;
        hs_cnt = 0;
        gn     = 0;
    endtask

    task automatic wait_done(input string tag, input int lim);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < lim && !seen; i++) begin
            nxt();
            #1;
            if (done) seen = 1'b1;
        end
        chk(tag, seen, 1);
    endtask

    initial begin
        rst_n = 1'b0; en = 1'b1; vld = '0; crdy = 1'b1; cidle = 1'b1;
        len = '0;
        dat = {16'h4444, 16'h3333, 16'h2222, 16'h1111};

        // Reset state
        nxt(); #1;
        chk("rst_gid",  gid,  0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_cvld", cvld, 0);
        chk("rst_rdy",  rdy,  0);
        do_reset();

        // Single request, req 2, len=3; first held off by enable_i=0
        en = 1'b0; vld = 4'b0100; len = 8'hFF; crdy = 1'b1; cidle = 1'b1;
        nxt(); nxt(); #1;
        chk("en0_busy", busy, 0);
        en = 1'b1;
        #1;
        chk("t1_idle_cvld", cvld, 0);
        nxt(); #1;
        chk("t1_gid",  gid,  2);
        chk("t1_busy", busy, 1);
        chk("t1_cvld", cvld, 1);
        chk("t1_cdat", cdat, 16'h3333);
        chk("t1_rdy",  rdy,  4'b0100);
        wait_done("t1_done_seen", 20);
        vld = '0;
        nxt(); #1;
        chk("t1_hs",    hs_cnt, 4);
        chk("t1_ndone", gn,     1);
        chk("t1_busy0", busy,   0);
        chk("t1_done0", done,   0);
        chk("t1_gid_hold", gid, 2);

        // Fairness: everyone valid, len=0
        do_reset();
        vld = 4'b1111; len = 8'h00;
        for (int i = 0; i < 60 && gn < 5; i++) nxt();
        vld = '0;
        chk("fair_n", gn, 5);
        chk("fair_0", glog[0], 0);
        chk("fair_1", glog[1], 1);
        chk("fair_2", glog[2], 2);
        chk("fair_3", glog[3], 3);
        chk("fair_4", glog[4], 0);

        // Backpressure: req 1, len=1, conv_ready_i toggling
        do_reset();
        vld = 4'b0010; len = 8'h55; crdy = 1'b0;
        for (int i = 0; i < 4; i++) begin
            nxt();
            crdy = (i % 2 == 0);
            #1;
            chk("bp_rdy",  rdy,  (i < 3 && crdy) ? 4'b0010 : 4'b0000);
            chk("bp_cvld", cvld, (i < 3) ? 1 : 0);
        end
        chk("bp_done", done, 1);
        vld = '0;
        crdy = 1'b0;
        nxt();
        crdy = 1'b1;
        nxt(); #1;
        chk("bp_hs",   hs_cnt, 2);
        chk("bp_busy", busy,   0);

        // Drain hold: conv_idle_i low for 7 cycles after the last word
        do_reset();
        vld = 4'b0001; len = 8'h00; crdy = 1'b1; cidle = 1'b0;
        nxt(); #1;
        chk("dr_xfer", cvld, 1);
        for (int i = 0; i < 7; i++) begin
            nxt();
            if (i == 0) vld = 4'b0011;
            #1;
            chk("dr_busy", busy, 1);
            chk("dr_done", done, 0);
            chk("dr_cvld", cvld, 0);
            chk("dr_gid",  gid,  0);
        end
        nxt();
        cidle = 1'b1; vld = '0;
        #1;
        chk("dr_pulse", done, 1);
        nxt(); #1;
        chk("dr_busy0", busy,   0);
        chk("dr_ndone", gn,     1);
        chk("dr_hs",    hs_cnt, 1);

        // Max length (len=3 with LEN_W=2); len and enable changed mid-burst
        do_reset();
        vld = 4'b1000; len = 8'hFF;
        nxt(); #1;
        chk("ml_gid", gid, 3);
        nxt();
        len = 8'h00; en = 1'b0;
        wait_done("ml_done_seen", 20);
        vld = '0; en = 1'b1;
        nxt(); #1;
        chk("ml_hs",    hs_cnt, 4);
        chk("ml_ndone", gn,     1);

        // Reset after 2 of 4 words
        do_reset();
        vld = 4'b0100; len = 8'hFF;
        nxt(); nxt(); nxt();
        rst_n = 1'b0;
        #1;
        chk("mr_busy", busy,   0);
        chk("mr_gid",  gid,    0);
        chk("mr_cvld", cvld,   0);
        chk("mr_rdy",  rdy,    0);
        chk("mr_done", done,   0);
        chk("mr_hs",   hs_cnt, 2);
        nxt();
        rst_n = 1'b1; vld = 4'b1111; len = 8'h00; gn = 0;
        nxt(); #1;
        chk("mr_busy1", busy, 1);
        chk("mr_cdat",  cdat, 16'h1111);
        chk("mr_rdy0",  rdy,  4'b0001);
        vld = 4'b0001;
        wait_done("mr_done_seen", 20);
        vld = '0;
        nxt(); #1;
        chk("mr_ndone", gn,      1);
        chk("mr_glog",  glog[0], 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
